setuphold_monitor: RTL and testbench
====================================

// Module: setuphold_monitor
// PURPOSE
//  Synthesizable observer for a setup/hold-checked capture point; checks from the receive side what stimulus provokes.
//  Oversamples an async data line (d_in) and a clock-edge strobe (ref_edge) on fast clk.
//  Measures the data-edge distance from each strobe and flags setup/hold violations; counts them.
//  Provides a reference capture model (q_model/q_valid) for comparison against the gate-level flop.
// PARAMETERS
//  SETUP_TICKS  5  min clean samples required before ref_edge (a toggle at distance < SETUP_TICKS violates)
//  HOLD_TICKS   3  samples after ref_edge during which a d toggle violates hold (distance 1..HOLD_TICKS)
//  CNT_W        8  width of saturating violation counters
//  DIST_W       8  width of saturating since-last-toggle counter; must satisfy 2**DIST_W-1 >= SETUP_TICKS
// PORTS
//  clk         in   1       oversampling clock; all logic on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  d_in        in   1       asynchronous data under observation
//  ref_edge    in   1       synchronous 1-cycle strobe marking the capture-clock edge
//  clr_cnt     in   1       synchronous clear of both violation counters
//  setup_viol  out  1       1-cycle pulse: setup violation detected
//  hold_viol   out  1       1-cycle pulse: hold violation detected
//  q_model     out  1       d value captured at last ref_edge
//  q_valid     out  1       1 = last capture free of violation
//  setup_cnt   out  CNT_W   saturating setup-violation count
//  hold_cnt    out  CNT_W   saturating hold-violation count
// BEHAVIOUR
//  Reset: all outputs 0; internal toggle distance = saturated max (no false setup); FSM = IDLE.
//  Sync: d_in through 2-flop synchronizer; ref_edge delayed 2 stages internally so both share sample index n.
//  Toggle: d sampled at n != sample n-1. Suppressed for first 2 cycles after reset release (pipeline prime).
//  Distance counter: cleared to 0 on toggle; else +1, saturating at 2**DIST_W-1.
//  Setup: at ref sample n_r, distance (n_r - last toggle) < SETUP_TICKS -> setup_viol.
//    Toggle on same sample as ref (distance 0) = setup violation only, never hold.
//  FSM IDLE -> HOLD on ref sample; HOLD holds window counter 1..HOLD_TICKS.
//    HOLD: toggle in window -> hold_viol (at most once per window); window end -> IDLE.
//    New ref during HOLD: old window closes silently; new window restarts at 1; setup checked for new ref.
//  q_model <= synchronized d at ref sample; q_valid <= 0 on setup viol or later hold viol in that window, else 1.
//  Latency: setup_viol, q_model, q_valid registered 3 clk after ref_edge sampled high.
//    hold_viol asserted 3 clk after the violating d_in sample.
//  Both pulses may assert in the same cycle (hold of ref k coincides with setup of ref k+1).
//  Counters: +1 per pulse, saturate at 2**CNT_W-1; clr_cnt wins over same-cycle increment (result 0).
//  Reset mid-window: window abandoned, no pulse after rst_n release.
// STRUCTURE
//  Package setuphold_pkg: typedef enum {IDLE, HOLD} sh_state_e; SYNC_STAGES=2; common CNT_W default.
//  Sub-module sat_counter #(W) (inc, clr, q; saturating), instantiated for setup_cnt, hold_cnt, distance.
//  Synchronizer, edge detect, FSM inline in setuphold_monitor.
// TESTING (SETUP_TICKS=5, HOLD_TICKS=3, CNT_W=2, clk period 1 sample)
//  1 d 0->1 8 samples before ref, stable 6 after -> no pulses, q_model=1, q_valid=1, counts 0.
//  2 d 0->1 2 samples before ref -> setup_viol 3 clk after ref, setup_cnt=1, q_valid=0.
//  3 d toggles 2 samples after ref -> hold_viol pulse, hold_cnt=1, q_valid=0; toggle at +4 -> none.
//  4 toggles at -2 and +1 -> both pulses, both counts +1; toggle on ref sample -> setup only.
//  5 five setup violations -> setup_cnt saturates at 3; clr_cnt with a pulse in same cycle -> 0.
//  6 rst_n low 1 sample after ref, d toggles in window -> no hold_viol, all outputs 0;
//    d_in=1 at release -> no toggle/setup pulse.

Source files
------------

// File: rtl/setuphold_pkg.sv
// Shared types and constants for the setup/hold capture-point monitor.
package setuphold_pkg;
    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} sh_state_e;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W_DEF   = 8;
endpackage

// File: rtl/setuphold_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int           W       = 8,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_q <= RST_VAL;
        else if (i_clr)
            o_q <= '0;
        else if (i_inc && (o_q != {W{1'b1}}))
            o_q <= o_q + W'(1);
    end
endmodule

// File: rtl/setuphold_monitor.sv
// Oversampling observer: measures data-toggle distance around each ref strobe,
// flags setup/hold violations, counts them, and models the captured value.
module setuphold_monitor
    import setuphold_pkg::*;
#(
    parameter int SETUP_TICKS = 5,
    parameter int HOLD_TICKS  = 3,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DIST_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             d_in,
    input  logic             ref_edge,
    input  logic             clr_cnt,
    output logic             setup_viol,
    output logic             hold_viol,
    output logic             q_model,
    output logic             q_valid,
    output logic [CNT_W-1:0] setup_cnt,
    output logic [CNT_W-1:0] hold_cnt
);
    localparam int               WIN_W     = $clog2(HOLD_TICKS + 1);
    localparam logic [DIST_W-1:0] SETUP_LIM = DIST_W'(SETUP_TICKS - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(HOLD_TICKS);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_ref;
    logic [SYNC_STAGES:0]   r_vld;
    logic                   r_prev;
    logic                   r_tog;
    logic                   r_refs;
    logic                   r_d;
    sh_state_e              r_state;
    logic [WIN_W-1:0]       r_win;
    logic                   r_hflag;
    logic [DIST_W-1:0]      w_dist;
    logic                   w_setup;
    logic                   w_hold;

    // Toggle is qualified only once r_prev holds a real post-reset sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_ref  <= '0;
            r_vld  <= '0;
            r_prev <= 1'b0;
            r_tog  <= 1'b0;
            r_refs <= 1'b0;
            r_d    <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
            r_ref  <= {r_ref[SYNC_STAGES-2:0], ref_edge};
            r_vld  <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_tog  <= r_vld[SYNC_STAGES] & (r_sync[SYNC_STAGES-1] ^ r_prev);
            r_refs <= r_ref[SYNC_STAGES-1];
            r_d    <= r_sync[SYNC_STAGES-1];
        end
    end

    // w_dist is the distance as of the previous sample; a toggle now means distance 0.
    assign w_setup = r_refs & (r_tog | (w_dist < SETUP_LIM));
    assign w_hold  = r_tog & (r_state == HOLD) & ~r_hflag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_win      <= '0;
            r_hflag    <= 1'b0;
            setup_viol <= 1'b0;
            hold_viol  <= 1'b0;
            q_model    <= 1'b0;
            q_valid    <= 1'b0;
        end else begin
            setup_viol <= w_setup;
            hold_viol  <= w_hold;
            if (r_refs) begin
                q_model <= r_d;
                q_valid <= ~w_setup;
                r_state <= HOLD;
                r_win   <= WIN_W'(1);
                r_hflag <= 1'b0;
            end else if (r_state == HOLD) begin
                if (w_hold) begin
                    r_hflag <= 1'b1;
                    q_valid <= 1'b0;
                end
                if (r_win == WIN_LAST)
                    r_state <= IDLE;
                else
                    r_win <= r_win + WIN_W'(1);
            end
        end
    end

    sat_counter #(.W(DIST_W), .RST_VAL({DIST_W{1'b1}})) u_dist (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(1'b1), .i_clr(r_tog), .o_q(w_dist)
    );
    sat_counter #(.W(CNT_W)) u_setup_cnt (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(w_setup), .i_clr(clr_cnt), .o_q(setup_cnt)
    );
    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .i_clk(clk), .i_rst_n(rst_n), .i_inc(w_hold), .i_clr(clr_cnt), .o_q(hold_cnt)
    );
endmodule

// File: tb/tb_setuphold_monitor.sv
// Bench for setuphold_monitor: directed offset table, hand corner sequences and
// random stimulus checked every cycle against a sample-history reference model.
module tb_setuphold_monitor;
    localparam int SETUP = 5;
    localparam int HOLD  = 3;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          d_in = 1'b0;
    logic          ref_edge = 1'b0;
    logic          clr_cnt = 1'b0;
    logic          setup_viol, hold_viol, q_model, q_valid;
    logic [CW-1:0] setup_cnt, hold_cnt;

    setuphold_monitor #(.SETUP_TICKS(SETUP), .HOLD_TICKS(HOLD), .CNT_W(CW), .DIST_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .d_in(d_in), .ref_edge(ref_edge), .clr_cnt(clr_cnt),
        .setup_viol(setup_viol), .hold_viol(hold_viol), .q_model(q_model), .q_valid(q_valid),
        .setup_cnt(setup_cnt), .hold_cnt(hold_cnt)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;
    bit dq [0:4095];
    bit rq [0:4095];
    bit cq [0:4095];
    int cur = 0;
    int ecs = 0;
    int ech = 0;
    bit dcur = 1'b0;
    bit saw_s, saw_h;

    typedef struct {
        int off;
        bit e_setup;
        bit e_hold;
        bit e_qv;
        bit e_flip;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s at sample %0d: got=%0d expected=%0d", name, cur, act, exp);
        end
    endtask

    function automatic bit tog(int i);
        return (i >= 1) && (dq[i] != dq[i-1]);
    endfunction

    function automatic bit setup_at(int n);
        if (n < 0 || !rq[n]) return 1'b0;
        for (int t = n - SETUP + 1; t <= n; t++)
            if (t >= 0 && tog(t)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int last_ref(int n);
        for (int k = n; k >= 0; k--)
            if (rq[k]) return k;
        return -1;
    endfunction

    // A toggle violates hold of the newest earlier ref if within HOLD samples and first in that window.
    function automatic bit hold_at(int n);
        int k;
        if (n < 1 || !tog(n)) return 1'b0;
        k = last_ref(n - 1);
        if (k < 0 || n - k > HOLD) return 1'b0;
        for (int t = k + 1; t < n; t++)
            if (tog(t)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic check_edge(input int e);
        int n, k;
        bit ps, ph, qm, qv;
        n  = e - 3;
        ps = setup_at(n);
        ph = hold_at(n);
        k  = (n >= 0) ? last_ref(n) : -1;
        qm = 1'b0;
        qv = 1'b0;
        if (k >= 0) begin
            qm = dq[k];
            qv = !setup_at(k);
            for (int t = k + 1; t <= n && t <= k + HOLD; t++)
                if (tog(t)) qv = 1'b0;
        end
        ecs = cq[e] ? 0 : ((ecs + int'(ps) > CMAX) ? CMAX : ecs + int'(ps));
        ech = cq[e] ? 0 : ((ech + int'(ph) > CMAX) ? CMAX : ech + int'(ph));
        chk("setup_viol", int'(setup_viol), int'(ps));
        chk("hold_viol", int'(hold_viol), int'(ph));
        chk("q_model", int'(q_model), int'(qm));
        chk("q_valid", int'(q_valid), int'(qv));
        chk("setup_cnt", int'(setup_cnt), ecs);
        chk("hold_cnt", int'(hold_cnt), ech);
    endtask

    task automatic step(input bit d, input bit r, input bit c);
        d_in = d; ref_edge = r; clr_cnt = c;
        dq[cur] = d; rq[cur] = r; cq[cur] = c;
        @(posedge clk);
        #1;
        check_edge(cur);
        saw_s |= setup_viol;
        saw_h |= hold_viol;
        cur++;
        dcur = d;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_setup_viol"}, int'(setup_viol), 0);
        chk({tag, "_hold_viol"}, int'(hold_viol), 0);
        chk({tag, "_q_model"}, int'(q_model), 0);
        chk({tag, "_q_valid"}, int'(q_valid), 0);
        chk({tag, "_setup_cnt"}, int'(setup_cnt), 0);
        chk({tag, "_hold_cnt"}, int'(hold_cnt), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cur = 0; ecs = 0; ech = 0;
    endtask

    initial begin
        int gap;
        bit base, r, c;
        tbl[0] = '{-8, 0, 0, 1, 1};
        tbl[1] = '{-5, 0, 0, 1, 1};
        tbl[2] = '{-4, 1, 0, 0, 1};
        tbl[3] = '{-2, 1, 0, 0, 1};
        tbl[4] = '{ 0, 1, 0, 0, 1};
        tbl[5] = '{ 1, 0, 1, 0, 0};
        tbl[6] = '{ 2, 0, 1, 0, 0};
        tbl[7] = '{ 3, 0, 1, 0, 0};
        tbl[8] = '{ 4, 0, 0, 1, 0};

        #2;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        release_reset();
        repeat (4) step(1'b0, 1'b0, 1'b0);

        // Toggle placed at each offset around a single ref strobe.
        foreach (tbl[v]) begin
            base = dcur;
            saw_s = 0; saw_h = 0;
            for (int i = -10; i <= 8; i++)
                step((i >= tbl[v].off) ? !base : base, i == 0, 1'b0);
            chk($sformatf("tbl%0d_setup_seen", tbl[v].off), int'(saw_s), int'(tbl[v].e_setup));
            chk($sformatf("tbl%0d_hold_seen", tbl[v].off), int'(saw_h), int'(tbl[v].e_hold));
            chk($sformatf("tbl%0d_q_valid", tbl[v].off), int'(q_valid), int'(tbl[v].e_qv));
            chk($sformatf("tbl%0d_q_model", tbl[v].off), int'(q_model), int'(base ^ tbl[v].e_flip));
        end

        // Saturation at 3, then clear coinciding with a setup pulse.
        step(dcur, 1'b0, 1'b1);
        chk("clr_setup_cnt", int'(setup_cnt), 0);
        repeat (5) begin
            step(!dcur, 1'b1, 1'b0);
            repeat (5) step(dcur, 1'b0, 1'b0);
        end
        chk("sat_setup_cnt", int'(setup_cnt), CMAX);
        step(!dcur, 1'b1, 1'b0);
        step(dcur, 1'b0, 1'b0);
        step(dcur, 1'b0, 1'b0);
        step(dcur, 1'b0, 1'b1);
        chk("clr_pulse_setup_viol", int'(setup_viol), 1);
        chk("clr_pulse_setup_cnt", int'(setup_cnt), 0);
        repeat (6) step(dcur, 1'b0, 1'b0);

        // Random traffic; refs spaced beyond the hold window.
        gap = 3;
        for (int i = 0; i < 400; i++) begin
            r = 1'b0;
            if (gap == 0) begin r = 1'b1; gap = $urandom_range(12, 4); end
            else gap--;
            c = ($urandom_range(49) == 0);
            step(($urandom_range(3) == 0) ? !dcur : dcur, r, c);
        end
        repeat (6) step(dcur, 1'b0, 1'b0);

        // Reset inside a hold window, d toggling while held, d high at release.
        step(1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("midreset");
        d_in = 1'b1;
        @(posedge clk);
        #1 d_in = 1'b0;
        @(posedge clk);
        #1 d_in = 1'b1;
        release_reset();
        saw_s = 0; saw_h = 0;
        repeat (12) step(1'b1, 1'b0, 1'b0);
        chk("post_reset_setup_seen", int'(saw_s), 0);
        chk("post_reset_hold_seen", int'(saw_h), 0);
        chk("post_reset_q_valid", int'(q_valid), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
